baud_tick_gen: RTL and testbench
================================

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, integer-divisor width.
REQ-002 SHALL have parameter FRAC_W, default 4, fractional-divisor width.
REQ-003 SHALL have parameter OVS, default 16, oversample ticks per bit (>=2).
REQ-004 SHALL have parameter DEF_INT, default 3, reset integer divisor.
REQ-005 SHALL have parameter DEF_FRAC, default 12, reset fractional divisor.
REQ-006 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port en  in  1  generator enable.
REQ-009 SHALL have port div_int  in  DIV_W  integer divisor, cycles per oversample tick.
REQ-010 SHALL have port div_frac  in  FRAC_W  fractional divisor, units of 1/2^FRAC_W cycle.
REQ-011 SHALL have port div_load  in  1  one-cycle strobe capturing div_int/div_frac.
REQ-012 SHALL have port os_tick  out  1  one-cycle oversample pulse.
REQ-013 SHALL have port bit_tick  out  1  one-cycle bit-rate pulse.
REQ-014 SHALL have port cfg_err  out  1  high while active integer divisor < 2.

Function
REQ-015 SHALL hold active divisor (act_int, act_frac), pending divisor (pend_int, pend_frac), pend_valid flag, cycle counter, FRAC_W-bit accumulator, os counter 0..OVS-1.
REQ-016 SHALL, on div_load, capture inputs into pending registers and set pend_valid; a later div_load before transfer overwrites pending.
REQ-017 SHALL transfer pending to active in the terminal cycle of the current period (or the first cycle with en=0); div_load coinciding with the terminal cycle loads the inputs straight to active for the next period; pend_valid clears on transfer.
REQ-018 SHALL compute each period length = max(act_int,2) + carry, carry = carry-out of (acc + act_frac), acc updated to low FRAC_W bits of that sum at period start.
REQ-019 SHALL assert os_tick, registered, for exactly one clk cycle per period; the first os_tick follows exactly one full period after the first rising edge with en=1.
REQ-020 SHALL advance the os counter on each os_tick, asserting bit_tick coincident with the os_tick at which the os counter equals OVS-1, then wrap to 0.
REQ-021 SHALL, while en=0, hold cycle counter, os counter and acc at 0 and drive os_tick=bit_tick=0; pending capture still operates.
REQ-022 SHALL drive cfg_err=1 combinationally from act_int<2 while using period base 2.
REQ-023 SHALL never assert bit_tick without os_tick in the same cycle.
REQ-024 SHALL, on en deassert mid-period, abandon the partial period with no tick issued.

Reset
REQ-025 SHALL, on reset low, immediately clear counters, acc, pend_valid, os_tick, bit_tick, and load act_int=DEF_INT, act_frac=DEF_FRAC; cfg_err reflects DEF_INT.
REQ-026 SHALL apply reset asserted mid-period with no tick and no pending transfer; counting restarts from 0 on the first edge after release with en=1.

Configuration
REQ-027 SHALL support macro BAUD_TICK_FRAC_EN.
REQ-028 SHALL, with BAUD_TICK_FRAC_EN defined, implement the fractional accumulator per REQ-018.
REQ-029 SHALL, without BAUD_TICK_FRAC_EN, omit the accumulator and act_frac/pend_frac storage, ignore div_frac, and use period = max(act_int,2) exactly.

Verification
REQ-030 SHALL verify: reset defaults (3,12), en=1, BAUD_TICK_FRAC_EN on -> periods repeat 3,4,4,4; 64 os_ticks in 240 cycles; bit_tick every 60 cycles (9600 baud at 576 kHz).
REQ-031 SHALL verify: BAUD_TICK_FRAC_EN off, div_int=6 loaded -> os_tick every 6 cycles, bit_tick every 96 cycles.
REQ-032 SHALL verify: div_load of 10 mid-period of a 3-cycle divisor -> current period completes at 3, next period is 10.
REQ-033 SHALL verify: div_int=1 loaded -> cfg_err=1, os_tick period 2; then div_int=5 loaded -> cfg_err=0 after transfer, period 5.
REQ-034 SHALL verify: en dropped 2 cycles into a period then restored -> no tick during low, first os_tick one full period after restore, os counter restarted at 0.
REQ-035 SHALL verify: reset asserted asynchronously between clk edges during os_tick -> os_tick and bit_tick low immediately, active divisor back to (3,12).

Source files
------------

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable oversample / bit-rate tick generator.
// Each oversample period lasts max(act_int,2) clk cycles. When the optional
// macro BAUD_TICK_FRAC_EN is defined, a fractional accumulator can stretch a
// period by one cycle so that the average period is act_int + act_frac/2^FRAC_W.
// New divisors are staged in a pending register and become active only at a
// period boundary (or while the generator is disabled).
module baud_tick_gen #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int DEF_INT  = 3,
  parameter int DEF_FRAC = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              cfg_err
);

  localparam int              OS_W    = $clog2(OVS);
  localparam int              CNT_W   = DIV_W + 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);

  logic [DIV_W-1:0] act_int_reg, act_int_next;
  logic [DIV_W-1:0] pend_int_reg, pend_int_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [CNT_W-1:0] cyc_cnt_reg;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] base_len, len_next;
  logic [OS_W-1:0]  os_cnt_reg;
  logic             os_tick_reg, bit_tick_reg;
  logic             start, terminal, xfer, carry;

`ifdef BAUD_TICK_FRAC_EN
  logic [FRAC_W-1:0] act_frac_reg, act_frac_next;
  logic [FRAC_W-1:0] pend_frac_reg, pend_frac_next;
  logic [FRAC_W-1:0] acc_reg, acc_next;
  logic [FRAC_W:0]   acc_sum;
`else
  // Fractional input has no effect in the integer-only build.
  logic unused_div_frac;
  assign unused_div_frac = ^div_frac;
`endif

  // start: first enabled edge after idle; terminal: last cycle of a period.
  // cyc_cnt_reg runs 1..len_reg inside a period and is 0 only while idle.
  assign start    = en && (cyc_cnt_reg == '0);
  assign terminal = en && (cyc_cnt_reg != '0) && (cyc_cnt_reg == len_reg);
  assign xfer     = terminal || !en;

  assign os_tick  = os_tick_reg;
  assign bit_tick = bit_tick_reg;
  assign cfg_err  = (act_int_reg < DIV_W'(2));

  // Divisor staging: a load in the terminal cycle bypasses pending straight to active.
  always_comb begin
    act_int_next    = act_int_reg;
    pend_int_next   = pend_int_reg;
    pend_valid_next = pend_valid_reg;
`ifdef BAUD_TICK_FRAC_EN
    act_frac_next   = act_frac_reg;
    pend_frac_next  = pend_frac_reg;
`endif
    if (terminal && div_load) begin
      act_int_next    = div_int;
      pend_valid_next = 1'b0;
`ifdef BAUD_TICK_FRAC_EN
      act_frac_next   = div_frac;
`endif
    end else begin
      if (xfer && pend_valid_reg) begin
        act_int_next    = pend_int_reg;
        pend_valid_next = 1'b0;
`ifdef BAUD_TICK_FRAC_EN
        act_frac_next   = pend_frac_reg;
`endif
      end
      if (div_load) begin
        pend_int_next   = div_int;
        pend_valid_next = 1'b1;
`ifdef BAUD_TICK_FRAC_EN
        pend_frac_next  = div_frac;
`endif
      end
    end
  end

  // Length of the period that begins at this edge, using the divisor it will run with.
  always_comb begin
    base_len = (act_int_next < DIV_W'(2)) ? CNT_W'(2) : {1'b0, act_int_next};
`ifdef BAUD_TICK_FRAC_EN
    acc_sum  = {1'b0, acc_reg} + {1'b0, act_frac_next};
    carry    = acc_sum[FRAC_W];
    acc_next = acc_sum[FRAC_W-1:0];
`else
    carry    = 1'b0;
`endif
    len_next = base_len + CNT_W'(carry);
  end

  // Divisor registers; reset restores the default divisor and drops any pending load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_int_reg    <= DIV_W'(DEF_INT);
      pend_int_reg   <= '0;
      pend_valid_reg <= 1'b0;
`ifdef BAUD_TICK_FRAC_EN
      act_frac_reg   <= FRAC_W'(DEF_FRAC);
      pend_frac_reg  <= '0;
`endif
    end else begin
      act_int_reg    <= act_int_next;
      pend_int_reg   <= pend_int_next;
      pend_valid_reg <= pend_valid_next;
`ifdef BAUD_TICK_FRAC_EN
      act_frac_reg   <= act_frac_next;
      pend_frac_reg  <= pend_frac_next;
`endif
    end
  end

  // Period counter, oversample counter and registered tick outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt_reg  <= '0;
      len_reg      <= CNT_W'(2);
      os_cnt_reg   <= '0;
      os_tick_reg  <= 1'b0;
      bit_tick_reg <= 1'b0;
    end else if (!en) begin
      cyc_cnt_reg  <= '0;
      os_cnt_reg   <= '0;
      os_tick_reg  <= 1'b0;
      bit_tick_reg <= 1'b0;
    end else if (start || terminal) begin
      cyc_cnt_reg  <= CNT_W'(1);
      len_reg      <= len_next;
      os_tick_reg  <= terminal;
      bit_tick_reg <= terminal && (os_cnt_reg == OS_LAST);
      if (terminal) begin
        os_cnt_reg <= (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + 1'b1;
      end
    end else begin
      cyc_cnt_reg  <= cyc_cnt_reg + 1'b1;
      os_tick_reg  <= 1'b0;
      bit_tick_reg <= 1'b0;
    end
  end

`ifdef BAUD_TICK_FRAC_EN
  // Fractional accumulator advances once per period start and idles at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg <= '0;
    end else if (!en) begin
      acc_reg <= '0;
    end else if (start || terminal) begin
      acc_reg <= acc_next;
    end
  end
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed testbench for baud_tick_gen (default parameters).
// Expected periods depend on whether BAUD_TICK_FRAC_EN is defined.
module tb_baud_tick_gen;

`ifdef BAUD_TICK_FRAC_EN
  localparam int P_LONG    = 4;   // periods 2..4 after reset with (3,12)
  localparam int TICKS_240 = 64;
  localparam int BITS_240  = 4;
  localparam int FIRST_BIT = 61;
  localparam int BIT_GAP   = 60;
`else
  localparam int P_LONG    = 3;
  localparam int TICKS_240 = 80;
  localparam int BITS_240  = 5;
  localparam int FIRST_BIT = 49;
  localparam int BIT_GAP   = 48;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        os_tick, bit_tick, cfg_err;

  int checks = 0;
  int failures = 0;
  int n, ticks, bits, first_bit, last_bit, gap_bad, orphan, tcount, quiet;

  baud_tick_gen dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Negedges until os_tick is seen high (bounded).
  task automatic wait_os(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (os_tick !== 1'b1 && cnt < 2000);
  endtask

  task automatic load(input int di, input int df);
    div_int  = 16'(di);
    div_frac = 4'(df);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  // Count ticks/bit ticks over a window starting right after enable.
  task automatic window(input int len, input int gap);
    ticks = 0; bits = 0; first_bit = 0; last_bit = 0; gap_bad = 0; orphan = 0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (os_tick === 1'b1) ticks++;
      if (bit_tick === 1'b1 && os_tick !== 1'b1) orphan++;
      if (bit_tick === 1'b1) begin
        if (bits == 0) first_bit = i;
        else if (i - last_bit != gap) gap_bad++;
        last_bit = i;
        bits++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset defaults
    repeat (2) @(negedge clk);
    check("rst_os_tick", os_tick, 0);
    check("rst_bit_tick", bit_tick, 0);
    check("rst_cfg_err", cfg_err, 0);
    reset = 1'b1;
    @(negedge clk);

    // Default divisor cadence
    en = 1'b1;
    wait_os(n); check("def_first", n, 4);
    wait_os(n); check("def_p2", n, P_LONG);
    wait_os(n); check("def_p3", n, P_LONG);
    wait_os(n); check("def_p4", n, P_LONG);
    wait_os(n); check("def_p5", n, 3);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    window(241, BIT_GAP);
    check("def_ticks_240", ticks, TICKS_240);
    check("def_bits_240", bits, BITS_240);
    check("def_first_bit", first_bit, FIRST_BIT);
    check("def_bit_gap", gap_bad, 0);
    check("def_orphan_bit", orphan, 0);

    // Divisor 6
    en = 1'b0;
    load(6, 0);
    @(negedge clk);
    en = 1'b1;
    wait_os(n); check("d6_first", n, 7);
    wait_os(n); check("d6_period", n, 6);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    window(200, 96);
    check("d6_ticks", ticks, 33);
    check("d6_first_bit", first_bit, 97);
    check("d6_bit_gap", gap_bad, 0);
    check("d6_bits", bits, 2);

    // Mid-period load does not disturb the current period
    en = 1'b0;
    load(3, 0);
    @(negedge clk);
    en = 1'b1;
    wait_os(n); check("mid_first", n, 4);
    @(negedge clk);
    load(10, 0);
    wait_os(n); check("mid_finish", n + 2, 3);
    wait_os(n); check("mid_next10", n, 10);
    // Load coinciding with the terminal cycle applies to the next period
    repeat (9) @(negedge clk);
    check("term_pre_tick", os_tick, 0);
    load(4, 0);
    check("term_tick", os_tick, 1);
    wait_os(n); check("term_next4", n, 4);
    wait_os(n); check("term_again4", n, 4);

    // Divisor below 2 flags an error and runs at base 2
    en = 1'b0;
    load(1, 0);
    @(negedge clk);
    check("err_cfg_hi", cfg_err, 1);
    en = 1'b1;
    wait_os(n); check("err_first", n, 3);
    wait_os(n); check("err_period2", n, 2);
    div_int  = 16'd5;
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    check("err_cfg_pend", cfg_err, 1);
    check("err_no_tick", os_tick, 0);
    @(negedge clk);
    check("err_tick", os_tick, 1);
    check("err_cfg_lo", cfg_err, 0);
    wait_os(n); check("err_period5", n, 5);

    // Enable dropped two cycles into a period
    @(negedge clk);
    en = 1'b0;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (os_tick !== 1'b0 || bit_tick !== 1'b0) quiet++;
    end
    check("en_low_quiet", quiet, 0);
    en = 1'b1;
    wait_os(n); check("en_restore_first", n, 6);
    tcount = 1;
    while (bit_tick !== 1'b1 && tcount < 40) begin
      wait_os(n);
      tcount++;
    end
    check("en_bit_at_tick", tcount, 16);

    // Asynchronous reset during an os_tick
    en = 1'b0;
    load(7, 0);
    @(negedge clk);
    en = 1'b1;
    wait_os(n); check("ar_first7", n, 8);
    check("ar_tick_hi", os_tick, 1);
    reset = 1'b0;
    #1;
    check("ar_os_low", os_tick, 0);
    check("ar_bit_low", bit_tick, 0);
    check("ar_cfg", cfg_err, 0);
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    en = 1'b1;
    wait_os(n); check("ar_def_first", n, 4);
    wait_os(n); check("ar_def_p2", n, P_LONG);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
